sym5x5_window_mac: RTL and testbench

Downstream compute stage for the symmetric 5x5 filter. Consumes the five row taps produced by the scanline buffer chain (row4 = newest/live pixel, row0 = oldest) and builds a 5x5 sliding window. It applies the 6-coefficient symmetric kernel through a pipelined pre-add/multiply/accumulate datapath. It emits one filtered 8-bit pixel per window that lies fully inside the frame.

---
 rtl/sym5x5_window_mac_if.sv | 41 ++++
 rtl/sym5x5_window_mac.sv | 229 ++++++++++++++++++++++
 tb/tb_sym5x5_window_mac.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sym5x5_window_mac_if.sv
`default_nettype none
// ============================================================================
// Module   : sym5x5_window_mac_if
// Brief    : Column-tap input bus, frame/kernel configuration and pixel output
//            bundle for the symmetric 5x5 window MAC.
// Revision : 1.0 - initial release
// ============================================================================
interface sym5x5_window_mac_if;
    logic        enable;
    logic        valid_in;
    logic [7:0]  row0;
    logic [7:0]  row1;
    logic [7:0]  row2;
    logic [7:0]  row3;
    logic [7:0]  row4;
    logic [31:0] width;
    logic [31:0] height;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] f;
    logic [31:0] shift;
    logic [7:0]  pixel_out;
    logic        valid_out;
    logic        frame_done;

    modport master (
        output enable, valid_in, row0, row1, row2, row3, row4,
        output width, height, a, b, c, d, e, f, shift,
        input  pixel_out, valid_out, frame_done
    );

    modport slave (
        input  enable, valid_in, row0, row1, row2, row3, row4,
        input  width, height, a, b, c, d, e, f, shift,
        output pixel_out, valid_out, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/sym5x5_window_mac.sv
`default_nettype none
// ============================================================================
// Module   : sym5x5_window_mac
// Brief    : 5x5 sliding window with 6-coefficient symmetric kernel, pipelined
//            pre-add / multiply / accumulate / round. Optional output clamp
//            enabled by defining SYM5X5_SATURATE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sym5x5_window_mac #(
    parameter int COEF_W = 12,
    parameter int CNT_W  = 16,
    parameter int ACC_W  = 32
) (
    input wire                 clock,
    input wire                 resetn,
    sym5x5_window_mac_if.slave bus
);
    localparam int c_ps_w   = 11;
    localparam int c_prod_w = c_ps_w + 1 + COEF_W;
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_four = CNT_W'(4);

    typedef logic signed [ACC_W-1:0]    acc_t;
    typedef logic signed [c_prod_w-1:0] prod_t;

    function automatic logic [c_ps_w-1:0] zx8(input logic [7:0] v);
        return {{(c_ps_w-8){1'b0}}, v};
    endfunction

    logic [7:0]               w_tap [5];
    logic [7:0]               r_win [5][5];
    logic [CNT_W-1:0]         r_col;
    logic [CNT_W-1:0]         r_row;
    logic [CNT_W-1:0]         r_w;
    logic [CNT_W-1:0]         r_h;
    logic signed [COEF_W-1:0] r_coef [6];
    logic [4:0]               r_shift;
    logic                     r_s0_valid;
    logic                     r_s0_last;

    logic                     w_frame_start;
    logic [CNT_W-1:0]         w_w_eff;
    logic [CNT_W-1:0]         w_h_eff;
    logic                     w_col_last;
    logic                     w_row_last;
    logic                     w_win_valid;

    logic [c_ps_w-1:0]        w_ps [6];
    logic [c_ps_w-1:0]        r_s1_ps [6];
    logic signed [COEF_W-1:0] r_s1_coef [6];
    logic [4:0]               r_s1_shift;
    logic                     r_s1_valid;
    logic                     r_s1_last;

    prod_t                    w_prod [6];
    prod_t                    r_s2_prod [6];
    logic [4:0]               r_s2_shift;
    logic                     r_s2_valid;
    logic                     r_s2_last;

    acc_t                     w_sum;
    acc_t                     r_s3_acc;
    logic [4:0]               r_s3_shift;
    logic                     r_s3_valid;
    logic                     r_s3_last;

    acc_t                     w_biased;
    acc_t                     w_shifted;
    logic [7:0]               w_pix;
    logic [7:0]               r_pixel;
    logic                     r_valid_out;
    logic                     r_frame_done;

    assign w_tap[0] = bus.row0;
    assign w_tap[1] = bus.row1;
    assign w_tap[2] = bus.row2;
    assign w_tap[3] = bus.row3;
    assign w_tap[4] = bus.row4;

    // The frame-start beat must already wrap on the incoming size, before the
    // shadow copy of it becomes visible.
    assign w_frame_start = (r_col == '0) && (r_row == '0);
    assign w_w_eff       = w_frame_start ? bus.width[CNT_W-1:0]  : r_w;
    assign w_h_eff       = w_frame_start ? bus.height[CNT_W-1:0] : r_h;
    assign w_col_last    = (r_col == (w_w_eff - c_cnt_one));
    assign w_row_last    = (r_row == (w_h_eff - c_cnt_one));
    assign w_win_valid   = (r_col >= c_cnt_four) && (r_row >= c_cnt_four);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_col      <= '0;
            r_row      <= '0;
            r_w        <= '0;
            r_h        <= '0;
            r_shift    <= '0;
            r_s0_valid <= 1'b0;
            r_s0_last  <= 1'b0;
            for (int i = 0; i < 6; i++) r_coef[i] <= '0;
            for (int r = 0; r < 5; r++)
                for (int k = 0; k < 5; k++) r_win[r][k] <= '0;
        end else if (bus.enable) begin
            r_s0_valid <= 1'b0;
            r_s0_last  <= 1'b0;
            if (bus.valid_in) begin
                for (int r = 0; r < 5; r++) begin
                    for (int k = 0; k < 4; k++) r_win[r][k] <= r_win[r][k+1];
                    r_win[r][4] <= w_tap[r];
                end
                r_s0_valid <= w_win_valid;
                r_s0_last  <= w_win_valid & w_col_last & w_row_last;
                if (w_frame_start) begin
                    r_w       <= bus.width[CNT_W-1:0];
                    r_h       <= bus.height[CNT_W-1:0];
                    r_coef[0] <= bus.a[COEF_W-1:0];
                    r_coef[1] <= bus.b[COEF_W-1:0];
                    r_coef[2] <= bus.c[COEF_W-1:0];
                    r_coef[3] <= bus.d[COEF_W-1:0];
                    r_coef[4] <= bus.e[COEF_W-1:0];
                    r_coef[5] <= bus.f[COEF_W-1:0];
                    r_shift   <= bus.shift[4:0];
                end
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : (r_row + c_cnt_one);
                end else begin
                    r_col <= r_col + c_cnt_one;
                end
            end
        end
    end

    // Pre-sums group the window by distance from the centre tap [2][2].
    always_comb begin
        w_ps[0] = zx8(r_win[2][2]);
        w_ps[1] = zx8(r_win[2][1]) + zx8(r_win[2][3]) + zx8(r_win[1][2]) + zx8(r_win[3][2]);
        w_ps[2] = zx8(r_win[1][1]) + zx8(r_win[1][3]) + zx8(r_win[3][1]) + zx8(r_win[3][3]);
        w_ps[3] = zx8(r_win[2][0]) + zx8(r_win[2][4]) + zx8(r_win[0][2]) + zx8(r_win[4][2]);
        w_ps[4] = zx8(r_win[1][0]) + zx8(r_win[1][4]) + zx8(r_win[3][0]) + zx8(r_win[3][4])
                + zx8(r_win[0][1]) + zx8(r_win[0][3]) + zx8(r_win[4][1]) + zx8(r_win[4][3]);
        w_ps[5] = zx8(r_win[0][0]) + zx8(r_win[0][4]) + zx8(r_win[4][0]) + zx8(r_win[4][4]);
    end

    always_comb begin
        for (int i = 0; i < 6; i++)
            w_prod[i] = prod_t'($signed({1'b0, r_s1_ps[i]})) * prod_t'(r_s1_coef[i]);
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < 6; i++) w_sum = w_sum + acc_t'(r_s2_prod[i]);
    end

    always_comb begin
        w_biased = r_s3_acc;
        if (r_s3_shift != 5'd0)
            w_biased = r_s3_acc + (acc_t'(1) <<< (r_s3_shift - 5'd1));
        w_shifted = w_biased >>> r_s3_shift;
    end

`ifdef SYM5X5_SATURATE_EN
    always_comb begin
        if (w_shifted < acc_t'(0))
            w_pix = 8'd0;
        else if (w_shifted > acc_t'(255))
            w_pix = 8'd255;
        else
            w_pix = w_shifted[7:0];
    end
`else
    logic w_unused_high;
    assign w_pix         = w_shifted[7:0];
    assign w_unused_high = ^w_shifted[ACC_W-1:8];
`endif

    // Coefficients and shift ride along from S1 so a frame's trailing outputs
    // are not disturbed when the next frame re-latches its shadow registers.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_s1_shift   <= '0;
            r_s1_valid   <= 1'b0;
            r_s1_last    <= 1'b0;
            r_s2_shift   <= '0;
            r_s2_valid   <= 1'b0;
            r_s2_last    <= 1'b0;
            r_s3_acc     <= '0;
            r_s3_shift   <= '0;
            r_s3_valid   <= 1'b0;
            r_s3_last    <= 1'b0;
            r_pixel      <= '0;
            r_valid_out  <= 1'b0;
            r_frame_done <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                r_s1_ps[i]   <= '0;
                r_s1_coef[i] <= '0;
                r_s2_prod[i] <= '0;
            end
        end else if (bus.enable) begin
            r_s1_shift   <= r_shift;
            r_s1_valid   <= r_s0_valid;
            r_s1_last    <= r_s0_last;
            r_s2_shift   <= r_s1_shift;
            r_s2_valid   <= r_s1_valid;
            r_s2_last    <= r_s1_last;
            r_s3_acc     <= w_sum;
            r_s3_shift   <= r_s2_shift;
            r_s3_valid   <= r_s2_valid;
            r_s3_last    <= r_s2_last;
            r_pixel      <= w_pix;
            r_valid_out  <= r_s3_valid;
            r_frame_done <= r_s3_last;
            for (int i = 0; i < 6; i++) begin
                r_s1_ps[i]   <= w_ps[i];
                r_s1_coef[i] <= r_coef[i];
                r_s2_prod[i] <= w_prod[i];
            end
        end
    end

    assign bus.pixel_out  = r_pixel;
    assign bus.valid_out  = r_valid_out;
    assign bus.frame_done = r_frame_done;

    logic w_unused_cfg;
    assign w_unused_cfg = ^{bus.width[31:CNT_W], bus.height[31:CNT_W],
                            bus.a[31:COEF_W], bus.b[31:COEF_W], bus.c[31:COEF_W],
                            bus.d[31:COEF_W], bus.e[31:COEF_W], bus.f[31:COEF_W],
                            bus.shift[31:5]};
endmodule
`default_nettype wire

// File: tb/tb_sym5x5_window_mac.sv
`default_nettype none
// ============================================================================
// Module   : tb_sym5x5_window_mac
// Brief    : Self-checking bench: frame-level reference model plus directed
//            literal expectations for sym5x5_window_mac.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sym5x5_window_mac;
    logic clock = 1'b0;
    logic resetn;

    sym5x5_window_mac_if bus ();

    sym5x5_window_mac #(.COEF_W(12), .CNT_W(16), .ACC_W(32)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clock = ~clock;

`ifdef SYM5X5_SATURATE_EN
    localparam int c_ovf_pos = 255;
    localparam int c_ovf_neg = 0;
`else
    localparam int c_ovf_pos = 136;
    localparam int c_ovf_neg = 56;
`endif

    typedef struct { int due; logic [7:0] px; logic fd; } exp_t;
    typedef struct { logic [7:0] px; logic fd; int ec; } obs_t;

    int   nchecks = 0;
    int   nerrors = 0;
    exp_t expq [$];
    obs_t obsq [$];
    int   beatq [$];
    int   ecount = 0;
    int   hold_hi = 0;
    bit   stall_req = 0;
    bit   rnd_gaps = 0;

    // reference model state: whole-frame pixel memory and frame parameters
    int img [32][32];
    int m_col, m_row, m_w, m_h, m_shift;
    int m_coef [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    function automatic int sx12(input logic [31:0] v);
        logic signed [11:0] t;
        t = v[11:0];
        return int'(t);
    endfunction

    function automatic int kidx(input int dr, input int dc);
        int x, y, lo, hi;
        x = (dr < 0) ? -dr : dr;
        y = (dc < 0) ? -dc : dc;
        lo = (x < y) ? x : y;
        hi = (x < y) ? y : x;
        if (hi == 0) return 0;
        if (hi == 1) return (lo == 0) ? 1 : 2;
        return (lo == 0) ? 3 : ((lo == 1) ? 4 : 5);
    endfunction

    function automatic logic [7:0] model_pixel(input int cr, input int cc);
        int acc;
        acc = 0;
        for (int dr = -2; dr <= 2; dr++)
            for (int dc = -2; dc <= 2; dc++)
                acc += m_coef[kidx(dr, dc)] * img[cr+dr][cc+dc];
        if (m_shift > 0) acc += (1 << (m_shift - 1));
        acc = acc >>> m_shift;
`ifdef SYM5X5_SATURATE_EN
        if (acc < 0) return 8'd0;
        if (acc > 255) return 8'd255;
`endif
        return acc[7:0];
    endfunction

    task automatic model_reset();
        m_col = 0;
        m_row = 0;
        expq.delete();
    endtask

    task automatic model_beat(input logic [7:0] tap [5]);
        exp_t ex;
        if (m_col == 0 && m_row == 0) begin
            m_w       = int'(bus.width[15:0]);
            m_h       = int'(bus.height[15:0]);
            m_coef[0] = sx12(bus.a);
            m_coef[1] = sx12(bus.b);
            m_coef[2] = sx12(bus.c);
            m_coef[3] = sx12(bus.d);
            m_coef[4] = sx12(bus.e);
            m_coef[5] = sx12(bus.f);
            m_shift   = int'(bus.shift[4:0]);
        end
        for (int k = 0; k < 5; k++)
            if (m_row - 4 + k >= 0) img[m_row-4+k][m_col] = int'(tap[k]);
        if (m_col >= 4 && m_row >= 4) begin
            ex.due = ecount + 4;
            ex.px  = model_pixel(m_row - 2, m_col - 2);
            ex.fd  = (m_col == m_w - 1) && (m_row == m_h - 1);
            expq.push_back(ex);
        end
        if (m_col == m_w - 1) begin
            m_col = 0;
            m_row = (m_row == m_h - 1) ? 0 : m_row + 1;
        end else begin
            m_col++;
        end
    endtask

    // compare process: every clock edge, outputs are checked against the model
    initial begin : monitor
        logic       s_rst, s_en, s_vin, prev_vo, prev_fd;
        logic [7:0] prev_px;
        logic [7:0] s_tap [5];
        obs_t       ob;
        prev_vo = 1'b0;
        prev_fd = 1'b0;
        prev_px = 8'd0;
        forever begin
            @(posedge clock);
            s_rst = resetn;
            s_en  = bus.enable;
            s_vin = bus.valid_in;
            s_tap = '{bus.row0, bus.row1, bus.row2, bus.row3, bus.row4};
            if (!s_rst) begin
                model_reset();
            end else if (s_en) begin
                ecount++;
                if (s_vin) begin
                    beatq.push_back(ecount);
                    model_beat(s_tap);
                end
            end
            #1;
            if (!s_rst) begin
                chk("reset_valid_out", bus.valid_out, 0);
                chk("reset_pixel_out", bus.pixel_out, 0);
                chk("reset_frame_done", bus.frame_done, 0);
            end else if (!s_en) begin
                if (prev_vo === 1'b1) hold_hi++;
                chk("hold_valid_out", bus.valid_out, prev_vo);
                chk("hold_pixel_out", bus.pixel_out, prev_px);
                chk("hold_frame_done", bus.frame_done, prev_fd);
            end else if (expq.size() > 0 && expq[0].due == ecount) begin
                chk("valid_out_due", bus.valid_out, 1);
                chk("pixel_out", bus.pixel_out, expq[0].px);
                chk("frame_done", bus.frame_done, expq[0].fd);
                void'(expq.pop_front());
            end else begin
                chk("valid_out_idle", bus.valid_out, 0);
                chk("frame_done_idle", bus.frame_done, 0);
            end
            if (s_rst && s_en && bus.valid_out === 1'b1) begin
                ob.px = bus.pixel_out;
                ob.fd = bus.frame_done;
                ob.ec = ecount;
                obsq.push_back(ob);
            end
            prev_vo = bus.valid_out;
            prev_px = bus.pixel_out;
            prev_fd = bus.frame_done;
        end
    end

    function automatic int opx(input int i);
        return (i < obsq.size()) ? int'(obsq[i].px) : -1;
    endfunction

    function automatic int ofd(input int i);
        return (i < obsq.size()) ? int'(obsq[i].fd) : -1;
    endfunction

    function automatic int count_px(input int v);
        int n;
        n = 0;
        foreach (obsq[i]) if (obsq[i].px == v) n++;
        return n;
    endfunction

    function automatic int first_latency();
        if (obsq.size() == 0 || beatq.size() < 37) return -1;
        return obsq[0].ec - beatq[36];
    endfunction

    task automatic clear_logs();
        obsq.delete();
        beatq.delete();
        hold_hi = 0;
    endtask

    task automatic cfg(input int w, input int h, input int k [6], input int s);
        bus.width  = w;
        bus.height = h;
        bus.a = k[0];
        bus.b = k[1];
        bus.c = k[2];
        bus.d = k[3];
        bus.e = k[4];
        bus.f = k[5];
        bus.shift = s;
    endtask

    task automatic set_taps(input logic [7:0] t [5]);
        bus.row0 = t[0];
        bus.row1 = t[1];
        bus.row2 = t[2];
        bus.row3 = t[3];
        bus.row4 = t[4];
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            bus.enable   = 1'b1;
            bus.valid_in = 1'b0;
        end
    endtask

    // kind 0: pixel(r,c)=16r+c, kind 1: constant cv, otherwise random taps
    task automatic beat(input int r, input int c, input int kind, input int cv);
        logic [7:0] t [5];
        logic [7:0] junk [5];
        for (int k = 0; k < 5; k++) begin
            junk[k] = 8'($urandom);
            if (kind == 0)      t[k] = (r - 4 + k >= 0) ? 8'(16 * (r - 4 + k) + c) : 8'd0;
            else if (kind == 1) t[k] = 8'(cv);
            else                t[k] = 8'($urandom);
        end
        @(negedge clock);
        if (stall_req && bus.valid_out === 1'b1) begin
            bus.enable   = 1'b0;
            bus.valid_in = 1'b1;
            set_taps(junk);
            repeat (5) @(negedge clock);
            stall_req = 0;
        end
        if (rnd_gaps) begin
            while ($urandom_range(0, 3) == 0) begin
                bus.valid_in = 1'b0;
                bus.enable   = ($urandom_range(0, 4) != 0);
                set_taps(junk);
                @(negedge clock);
            end
        end
        bus.enable   = 1'b1;
        bus.valid_in = 1'b1;
        set_taps(t);
    endtask

    task automatic send_frame(input int w, input int h, input int kind, input int cv,
                              input int mid_a, input int gap_at);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (r * w + c == gap_at) idle(3);
                if (r * w + c == (w * h) / 2) bus.a = mid_a;
                beat(r, c, kind, cv);
            end
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: run exceeded its time limit, checks %0d", nchecks);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int k [6];
        logic [7:0] z [5];
        z = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        resetn       = 1'b0;
        bus.enable   = 1'b0;
        bus.valid_in = 1'b0;
        set_taps(z);
        cfg(8, 6, '{1, 0, 0, 0, 0, 0}, 0);
        repeat (3) @(negedge clock);
        chk("reset_state_valid", bus.valid_out, 0);
        chk("reset_state_pixel", bus.pixel_out, 0);
        resetn = 1'b1;

        // identity kernel on a ramp image
        clear_logs();
        send_frame(8, 6, 0, 0, 1, -1);
        idle(8);
        chk("id_count", obsq.size(), 8);
        chk("id_first", opx(0), 34);
        chk("id_last", opx(7), 53);
        chk("id_done_last", ofd(7), 1);
        chk("id_done_once", ofd(0) + ofd(1) + ofd(2) + ofd(3) + ofd(4) + ofd(5) + ofd(6), 0);

        // box average with rounding
        cfg(8, 6, '{1, 1, 1, 1, 1, 1}, 4);
        clear_logs();
        send_frame(8, 6, 1, 16, 1, -1);
        idle(8);
        chk("box_count", obsq.size(), 8);
        chk("box_value", count_px(25), 8);
        chk("box_latency", first_latency(), 4);

        // wrap / clamp behaviour
        cfg(6, 5, '{1, 1, 1, 1, 1, 1}, 0);
        clear_logs();
        send_frame(6, 5, 1, 200, 1, -1);
        idle(8);
        chk("ovf_pos", opx(0), c_ovf_pos);
        cfg(6, 5, '{-1, 0, 0, 0, 0, 0}, 0);
        clear_logs();
        send_frame(6, 5, 1, 200, -1, -1);
        idle(8);
        chk("ovf_neg", opx(0), c_ovf_neg);

        // valid_in gap mid-row plus a 5-cycle enable stall while valid_out is high
        cfg(8, 6, '{1, 0, 0, 0, 0, 0}, 0);
        clear_logs();
        stall_req = 1;
        send_frame(8, 6, 0, 0, 1, 13);
        idle(8);
        chk("stall_count", obsq.size(), 8);
        chk("stall_value", opx(4), 50);
        chk("stall_hold_cycles", hold_hi, 5);

        // reset part-way through a frame, then a clean frame
        cfg(8, 6, '{3, 1, 2, 0, 1, 0}, 2);
        for (int i = 0; i < 20; i++) beat(i / 8, i % 8, 2, 0);
        @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        bus.valid_in = 1'b0;
        cfg(8, 6, '{1, 0, 0, 0, 0, 0}, 0);
        clear_logs();
        send_frame(8, 6, 0, 0, 1, -1);
        idle(8);
        chk("rst_latency", first_latency(), 4);
        chk("rst_first", opx(0), 34);
        chk("rst_count", obsq.size(), 8);

        // too narrow for any full window
        cfg(4, 10, '{1, 1, 1, 1, 1, 1}, 3);
        clear_logs();
        send_frame(4, 10, 2, 0, 1, -1);
        idle(8);
        chk("narrow_none", obsq.size(), 0);

        // mid-frame coefficient change applies only from the next frame
        cfg(6, 6, '{1, 0, 0, 0, 0, 0}, 0);
        clear_logs();
        send_frame(6, 6, 1, 10, 2, -1);
        send_frame(6, 6, 1, 10, 2, -1);
        idle(8);
        chk("shadow_count", obsq.size(), 8);
        chk("shadow_old", (opx(0) == 10) + (opx(1) == 10) + (opx(2) == 10) + (opx(3) == 10), 4);
        chk("shadow_new", (opx(4) == 20) + (opx(5) == 20) + (opx(6) == 20) + (opx(7) == 20), 4);

        // randomized frames, back-to-back, with bubbles and enable drops
        rnd_gaps = 1;
        for (int n = 0; n < 6; n++) begin
            int w, h;
            w = $urandom_range(5, 12);
            h = $urandom_range(5, 10);
            for (int i = 0; i < 6; i++) k[i] = int'($urandom);
            cfg(int'($urandom & 32'hFFFF0000) | w, int'($urandom & 32'hFFFF0000) | h,
                k, int'($urandom));
            send_frame(w, h, 2, 0, k[0], -1);
        end
        rnd_gaps = 0;
        idle(12);
        chk("drain_empty", expq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end
endmodule
`default_nettype wire
